// File: rtl/tick_seq_pkg.sv
// tick_seq_pkg: shared widths, FSM states and table slot layout for tick_sequencer
package tick_seq_pkg;
  localparam int DIV_W = 8;
  localparam int REP_W = 7;
  localparam int NSLOT = 4;
  localparam int SLOT_W = $clog2(NSLOT);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [REP_W-1:0] reps;
  } slot_t;
endpackage

// File: rtl/tick_div_core.sv
// tick_div_core: loadable divisor counter emitting a one-cycle tick on its terminal count
module tick_div_core
  import tick_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt;
  assign tick = run & (cnt == div_r - DIV_W'(1));
  // latch the period on load; count while running, restarting at the terminal count
  always_ff @(posedge clk)
    if (reset) begin
      div_r <= '0;
      cnt <= '0;
    end else if (load) begin
      div_r <= div;
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
endmodule

// File: rtl/tick_sequencer.sv
// tick_sequencer: walks a (divisor, repeat) slot table emitting divider ticks; TICK_SEQ_LOOP_EN repeats passes
module tick_sequencer
  import tick_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [REP_W-1:0]  cfg_reps,
  input  logic              start,
  input  logic              stop,
  output logic              tick,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [REP_W-1:0]  rep_cnt,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  slot_t tbl [NSLOT];
  slot_t cur;
  logic [SLOT_W-1:0] slot_n;
  logic [REP_W-1:0] rep_n, reps_r;
  logic done_n, load, last, en_slot, pass_end, wrap_arm;
  assign cfg_ready = !reset && state == IDLE;
  assign busy = state != IDLE;
  assign cur = tbl[slot_idx];
  assign en_slot = cur.div != '0 && cur.reps != '0;
  assign last = slot_idx == SLOT_W'(NSLOT - 1);
`ifdef TICK_SEQ_LOOP_EN
  logic any_en;
  // a pass only repeats when some slot would tick, so an empty table cannot spin in ARM
  always_comb begin
    any_en = 1'b0;
    for (int i = 0; i < NSLOT; i++) any_en = any_en | (tbl[i].div != '0 && tbl[i].reps != '0);
  end
  assign wrap_arm = any_en;
`else
  assign wrap_arm = 1'b0;
`endif
  tick_div_core u_core (
    .clk(clk),
    .reset(reset),
    .load(load),
    .run(state == RUN),
    .div(cur.div),
    .tick(tick)
  );
  // next state: slot stepping, pass completion and stop override
  always_comb begin
    state_n = state;
    slot_n = slot_idx;
    rep_n = rep_cnt;
    done_n = 1'b0;
    load = 1'b0;
    pass_end = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_n = ARM;
        slot_n = '0;
        rep_n = '0;
      end
      ARM: begin
        load = 1'b1;
        rep_n = '0;
        if (en_slot) state_n = RUN;
        else if (!last) slot_n = slot_idx + SLOT_W'(1);
        else pass_end = 1'b1;
      end
      RUN: if (tick) begin
        rep_n = rep_cnt + REP_W'(1);
        if (rep_cnt == reps_r - REP_W'(1)) begin
          if (!last) begin
            state_n = ARM;
            slot_n = slot_idx + SLOT_W'(1);
          end else pass_end = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pass_end) begin
      done_n = 1'b1;
      state_n = wrap_arm ? ARM : IDLE;
      slot_n = wrap_arm ? '0 : slot_idx;
    end
    if (stop) begin
      state_n = IDLE;
      slot_n = slot_idx;
      done_n = 1'b0;
    end
  end
  // state, counters, working repeat count and the config table
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      slot_idx <= '0;
      rep_cnt <= '0;
      reps_r <= '0;
      done <= 1'b0;
      for (int i = 0; i < NSLOT; i++) tbl[i] <= '0;
    end else begin
      state <= state_n;
      slot_idx <= slot_n;
      rep_cnt <= rep_n;
      done <= done_n;
      if (load) reps_r <= cur.reps;
      if (cfg_valid && cfg_ready) tbl[cfg_slot] <= {cfg_div, cfg_reps};
    end
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: scoreboard bench; a slot-table timing model predicts tick/done events per cycle
module tb_tick_sequencer;
  import tick_seq_pkg::*;
`ifdef TICK_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [SLOT_W-1:0] cfg_slot = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [REP_W-1:0] cfg_reps = '0;
  logic cfg_ready, tick, busy, done;
  logic [SLOT_W-1:0] slot_idx;
  logic [REP_W-1:0] rep_cnt;
  typedef struct {int cyc; bit dn; int slot; int rep; bit bz;} ev_t;
  ev_t q[$];
  int mdiv[NSLOT];
  int mreps[NSLOT];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  tick_sequencer dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_slot(cfg_slot), .cfg_div(cfg_div), .cfg_reps(cfg_reps),
    .start(start), .stop(stop), .tick(tick), .slot_idx(slot_idx),
    .rep_cnt(rep_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", n, a, x, cyc);
    end
  endtask

  function automatic void push(input int c, input bit dn, input int sl, input int r, input bit bz, input int s);
    if (c <= s) q.push_back('{c, dn, sl, r, bz});
  endfunction

  // Timeline model: cycle t0 is the first ARM; a disabled slot costs one cycle, an enabled
  // slot costs one ARM cycle plus div*reps RUN cycles with ticks at t+div*(r+1).
  // Events after the stop cycle s are dropped; returns the first idle cycle.
  function automatic int gen(input int t0, input int s);
    int t = t0;
    bit any = 1'b0;
    bit fin;
    for (int k = 0; k < NSLOT; k++) any |= (mdiv[k] != 0 && mreps[k] != 0);
    do begin
      for (int k = 0; k < NSLOT; k++) begin
        if (mdiv[k] == 0 || mreps[k] == 0) t++;
        else begin
          for (int r = 0; r < mreps[k]; r++) push(t + mdiv[k] * (r + 1), 1'b0, k, r, 1'b1, s);
          t += 1 + mdiv[k] * mreps[k];
        end
      end
      push(t, 1'b1, 0, 0, LOOP && any, s);
      fin = !(LOOP && any) || t > s;
    end while (!fin);
    return (t < s + 1) ? t : s + 1;
  endfunction

  // monitor: every tick/done must match the head of the expected-event queue
  always @(negedge clk) begin
    ev_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_event: got nothing at cycle %0d, want %s", q[0].cyc, q[0].dn ? "done" : "tick");
      void'(q.pop_front());
    end
    if (tick === 1'b1 || done === 1'b1) begin
      total++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        bad++;
        $display("FAIL unexpected_output: got tick=%b done=%b at cycle %0d, want none", tick, done, cyc);
      end else begin
        e = q.pop_front();
        if (e.dn ? !(done && !tick && busy == e.bz)
                 : !(tick && !done && slot_idx == SLOT_W'(e.slot) && rep_cnt == REP_W'(e.rep))) begin
          bad++;
          $display("FAIL event: got tick=%b done=%b slot=%0d rep=%0d busy=%b, want %s slot=%0d rep=%0d busy=%b at cycle %0d",
                   tick, done, slot_idx, rep_cnt, busy, e.dn ? "done" : "tick", e.slot, e.rep, e.bz, cyc);
        end
      end
    end
  end

  task automatic wr(input int sl, input int d, input int r);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_slot = SLOT_W'(sl);
    cfg_div = DIV_W'(d);
    cfg_reps = REP_W'(r);
    @(negedge clk);
    cfg_valid = 1'b0;
    mdiv[sl] = d;
    mreps[sl] = r;
  endtask

  task automatic run(input int soff_in);
    int soff, t0, s, e, lim;
    bit exp_b;
    soff = (LOOP && soff_in < 0) ? 60 : soff_in;
    t0 = cyc + 1;
    s = soff < 0 ? t0 + 100000 : t0 + soff;
    e = gen(t0, s);
    lim = soff < 0 ? e + 2 : ((e > s) ? e : s) + 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do begin
      exp_b = cyc >= t0 && cyc < e;
      chk("busy", busy, exp_b);
      chk("cfg_ready", cfg_ready, !exp_b);
      stop = cyc == s;
      cfg_valid = exp_b && $urandom_range(0, 1) == 1;
      cfg_slot = SLOT_W'($urandom);
      cfg_div = DIV_W'($urandom);
      cfg_reps = REP_W'($urandom);
      @(negedge clk);
    end while (cyc < lim);
    stop = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int t0;
    for (int i = 0; i < NSLOT; i++) begin
      mdiv[i] = 0;
      mreps[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_slot_idx", slot_idx, 0);
    chk("rst_rep_cnt", rep_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    run(-1);
    wr(0, 3, 2);
    run(-1);
    wr(0, 1, 1);
    wr(1, 2, 1);
    wr(2, 0, 1);
    wr(3, 4, 1);
    run(-1);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) begin
      chk("busy_after_start_stop", busy, 0);
      @(negedge clk);
    end
    wr(1, 0, 0);
    wr(2, 0, 0);
    wr(3, 0, 0);
    wr(0, 3, 2);
    run(3);
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(1, 3))
        wr($urandom_range(0, NSLOT - 1), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 6), $urandom_range(0, 3));
      run($urandom_range(0, 2) == 0 ? $urandom_range(0, 40) : -1);
    end
    wr(1, 0, 0);
    wr(2, 0, 0);
    wr(3, 0, 0);
    wr(0, 2, 3);
    run(40);
    wr(0, 4, 3);
    t0 = cyc + 1;
    void'(gen(t0, t0 + 6));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_ready", cfg_ready, 0);
    chk("midrst_slot_idx", slot_idx, 0);
    chk("midrst_rep_cnt", rep_cnt, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      mdiv[i] = 0;
      mreps[i] = 0;
    end
    run(-1);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
